// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage load/store initiator for a word-only data memory, with sub-word RMW stores.
// Optional DM_STORE_LOG_EN adds a store trace driven by a half-rate cycle counter.
module dm_access_ctrl #(
    parameter int ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        fault,
    output logic [31:0] dm_address,
    output logic        dm_we,
    output logic [31:0] dm_wd,
    output logic [31:0] dm_ins_address,
    input  logic [31:0] dm_out
);
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4, SW = 3'd5, SH = 3'd6;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      r_state;
    logic [31:0] r_rdata, r_wd, r_addr, r_pc;
    logic        r_done, r_fault;

    logic        w_idle, w_fault, w_load, w_sw, w_sub, w_go;
    logic [4:0]  w_sh;
    logic [31:0] w_shr, w_ext, w_merged;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_idle  = r_state == IDLE;
    assign w_load  = op < SW;
    assign w_sw    = op == SW;
    assign w_sub   = op > SW;
    assign w_fault = (|addr[31:ADDR_BITS])
                   | ((op == LW || op == SW) ? |addr[1:0]
                   : (op == LH || op == LHU || op == SH) ? addr[0] : 1'b0);
    assign w_go    = w_idle & req & ~w_fault;

    // Lane selection: little-endian bytes by addr[1:0], halves by addr[1]
    assign w_sh   = {addr[1:0], 3'b000};
    assign w_shr  = dm_out >> w_sh;
    assign w_byte = w_shr[7:0];
    assign w_half = addr[1] ? dm_out[31:16] : dm_out[15:0];

    assign w_ext = op == LW  ? dm_out
                 : op == LH  ? {{16{w_half[15]}}, w_half}
                 : op == LHU ? {16'h0000, w_half}
                 : op == LB  ? {{24{w_byte[7]}}, w_byte}
                 : {24'h000000, w_byte};

    assign w_merged = op == SH ? (addr[1] ? {wdata[15:0], dm_out[15:0]} : {dm_out[31:16], wdata[15:0]})
                    : (dm_out & ~(32'h0000_00FF << w_sh)) | ({24'h000000, wdata[7:0]} << w_sh);

    assign stall          = w_go & w_sub & ~clr;
    assign dm_we          = ((w_go & w_sw) | ~w_idle) & ~clr;
    assign dm_address     = w_idle ? {addr[31:2], 2'b00} : r_addr;
    assign dm_wd          = w_idle ? wdata : r_wd;
    assign dm_ins_address = w_idle ? pc : r_pc;
    assign rdata          = r_rdata;
    assign done           = r_done;
    assign fault          = r_fault;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_wd    <= '0;
            r_addr  <= '0;
            r_pc    <= '0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            if (!w_idle) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
            end else if (req && w_fault) begin
                r_fault <= 1'b1;
            end else if (req && w_load) begin
                r_rdata <= w_ext;
                r_done  <= 1'b1;
            end else if (req && w_sw) begin
                r_done  <= 1'b1;
            end else if (req) begin
                r_state <= WRITE;
                r_wd    <= w_merged;
                r_addr  <= {addr[31:2], 2'b00};
                r_pc    <= pc;
            end
        end
    end

`ifdef DM_STORE_LOG_EN
    logic [31:0] r_cnt;
    logic        r_tog;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
            r_tog <= 1'b0;
        end else begin
            r_tog <= ~r_tog;
            if (r_tog) r_cnt <= r_cnt + 32'd1;
            if (dm_we) $display("%d@%h: *%h <= %h", r_cnt, {20'h00003, dm_ins_address[11:0]}, dm_address, dm_wd);
        end
    end
`endif
endmodule
